// File: rtl/shift_request_conditioner.sv
// Conditions the paddle and neutral-button inputs for the gear shifter controller.
// Each raw input is synchronised and debounced. A clean press becomes a one-cycle
// request, and the request path then holds off new requests for a lockout period.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   raw_up       - upshift paddle (asynchronous, active-high)
//   raw_down     - downshift paddle (asynchronous, active-high)
//   raw_neutral  - neutral button (asynchronous, active-high)
//   upBut        - upshift request, one-cycle pulse
//   downBut      - downshift request, one-cycle pulse
//   neutralBut   - neutral request, one-cycle pulse
//   busy         - high while in LOCKOUT or CONFLICT
//   dropped      - one-cycle pulse when a press event is discarded
module shift_request_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned LOCKOUT_CYCLES  = 5000000,
   parameter int unsigned CNT_W           = 23
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_up,
   input  logic raw_down,
   input  logic raw_neutral,
   output logic upBut,
   output logic downBut,
   output logic neutralBut,
   output logic busy,
   output logic dropped
);

   localparam int unsigned NCH = 3;
   localparam int unsigned UP  = 0;
   localparam int unsigned DN  = 1;
   localparam int unsigned NEU = 2;
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOCKOUT  = 2'd1,
      CONFLICT = 2'd2
   } state_t;

   logic [NCH-1:0] raw;
   logic [NCH-1:0] s1_q, s2_q;
   logic [NCH-1:0] deb_q, deb_prev_q;
   logic [NCH-1:0] press_c;

   state_t           state_q, next_state;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             up_d, down_d, neutral_d, dropped_d;

   assign raw = {raw_neutral, raw_down, raw_up};

   // Two-flop synchroniser per channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
      end
   end

   // Per-channel debouncer: level follows s2 only after it has differed long enough
   for (genvar ch = 0; ch < NCH; ch++) begin : g_db
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q     <= '0;
            deb_q[ch] <= 1'b0;
         end else if (s2_q[ch] == deb_q[ch]) begin
            cnt_q <= '0;
         end else if (cnt_q == DB_LAST) begin
            cnt_q     <= '0;
            deb_q[ch] <= s2_q[ch];
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Previous debounced level, for rising-edge (press) detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_prev_q <= '0;
      end else begin
         deb_prev_q <= deb_q;
      end
   end

   assign press_c = deb_q & ~deb_prev_q;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lock_cnt_q <= '0;
         upBut      <= 1'b0;
         downBut    <= 1'b0;
         neutralBut <= 1'b0;
         dropped    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= next_state;
         lock_cnt_q <= lock_cnt_d;
         upBut      <= up_d;
         downBut    <= down_d;
         neutralBut <= neutral_d;
         dropped    <= dropped_d;
         busy       <= (next_state != IDLE);
      end
   end

   // Arbitration, lockout timing and conflict handling
   always_comb begin
      next_state = state_q;
      lock_cnt_d = lock_cnt_q;
      up_d       = 1'b0;
      down_d     = 1'b0;
      neutral_d  = 1'b0;
      dropped_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // Neutral wins outright; up+down together without neutral is ambiguous
            if (press_c[NEU]) begin
               neutral_d  = 1'b1;
               lock_cnt_d = LOCK_LAST;
               next_state = LOCKOUT;
            end else if (press_c[UP] && press_c[DN]) begin
               next_state = CONFLICT;
            end else if (press_c[UP]) begin
               up_d       = 1'b1;
               lock_cnt_d = LOCK_LAST;
               next_state = LOCKOUT;
            end else if (press_c[DN]) begin
               down_d     = 1'b1;
               lock_cnt_d = LOCK_LAST;
               next_state = LOCKOUT;
            end
         end
         LOCKOUT: begin
            dropped_d = |press_c;
            if (lock_cnt_q == '0) begin
               next_state = IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q - CNT_W'(1);
            end
         end
         CONFLICT: begin
            // Stay until both paddles are released
            dropped_d = |press_c;
            if (!deb_q[UP] && !deb_q[DN]) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_shift_request_conditioner.sv
// Scoreboard bench for shift_request_conditioner (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10).
module tb_shift_request_conditioner;

   localparam int unsigned DEB  = 4;
   localparam int unsigned LOCK = 10;

   logic clk = 1'b0;
   logic rst_n;
   logic raw_up, raw_down, raw_neutral;
   logic upBut, downBut, neutralBut, busy, dropped;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   // outs = {dropped, neutralBut, downBut, upBut}
   typedef struct {
      int         cyc;
      logic [3:0] outs;
   } exp_t;
   exp_t sb[$];

   shift_request_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .LOCKOUT_CYCLES (LOCK),
      .CNT_W          (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_up     (raw_up),
      .raw_down   (raw_down),
      .raw_neutral(raw_neutral),
      .upBut      (upBut),
      .downBut    (downBut),
      .neutralBut (neutralBut),
      .busy       (busy),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the scoreboard whenever the DUT presents a pulse
   always @(negedge clk) begin
      logic [3:0] o;
      o = {dropped, neutralBut, downBut, upBut};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL missing_pulse: got nothing, expected outs=%b at edge %0d", sb[0].outs, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (o != 4'b0000) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got outs=%b at edge %0d, expected none", o, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc || e.outs != o) begin
               errors++;
               $display("FAIL pulse: got outs=%b at edge %0d, expected outs=%b at edge %0d", o, cyc, e.outs, e.cyc);
            end
         end
      end
   end

   task automatic push(input int c, input logic [3:0] o);
      exp_t e;
      e.cyc  = c;
      e.outs = o;
      sb.push_back(e);
   endtask

   task automatic step_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_busy(input logic exp, input string name);
      checks++;
      if (busy !== exp) begin
         errors++;
         $display("FAIL busy_%s: got %b expected %b at edge %0d", name, busy, exp, cyc);
      end
   endtask

   task automatic expect_all_zero(input string name);
      checks++;
      if ({upBut, downBut, neutralBut, busy, dropped} !== 5'b0) begin
         errors++;
         $display("FAIL %s: got outs=%b expected 00000", name, {upBut, downBut, neutralBut, busy, dropped});
      end
   endtask

   initial begin
      int e;
      int d;
      int x;
      rst_n       = 1'b0;
      raw_up      = 1'b0;
      raw_down    = 1'b0;
      raw_neutral = 1'b0;
      step_to(3);
      expect_all_zero("reset_state");
      rst_n = 1'b1;
      step_to(6);

      // Single upshift: latency and lockout length
      e = cyc;
      raw_up = 1'b1;
      push(e + 7, 4'b0001);
      step_to(e + 6);  expect_busy(1'b0, "up_before");
      step_to(e + 7);  expect_busy(1'b1, "up_start");
      step_to(e + 16); expect_busy(1'b1, "up_lock_last");
      step_to(e + 17); expect_busy(1'b0, "up_lock_end");
      raw_up = 1'b0;
      step_to(e + 30);

      // Short glitches on raw_down are filtered out
      for (int w = 1; w <= 3; w++) begin
         raw_down = 1'b1;
         step_to(cyc + w);
         raw_down = 1'b0;
         step_to(cyc + 6);
         expect_busy(1'b0, "glitch");
      end
      step_to(cyc + 6);
      expect_busy(1'b0, "glitch_end");

      // Neutral beats up on the same edge
      e = cyc;
      raw_up = 1'b1;
      raw_neutral = 1'b1;
      push(e + 7, 4'b0100);
      step_to(e + 7);  expect_busy(1'b1, "neu_start");
      step_to(e + 22); expect_busy(1'b0, "neu_held_idle");
      raw_up = 1'b0;
      raw_neutral = 1'b0;
      step_to(e + 35);

      // Up+down conflict
      e = cyc;
      raw_up = 1'b1;
      raw_down = 1'b1;
      step_to(e + 6);  expect_busy(1'b0, "conf_before");
      step_to(e + 7);  expect_busy(1'b1, "conf_enter");
      step_to(e + 10);
      raw_up = 1'b0;
      step_to(e + 25); expect_busy(1'b1, "conf_down_held");
      d = cyc;
      raw_down = 1'b0;
      step_to(d + 6);  expect_busy(1'b1, "conf_leave_minus1");
      step_to(d + 7);  expect_busy(1'b0, "conf_leave");
      step_to(d + 20);

      // Press during lockout is dropped; held paddle needs a re-press
      e = cyc;
      raw_up = 1'b1;
      push(e + 7, 4'b0001);
      step_to(e + 2);
      raw_down = 1'b1;
      push(e + 9, 4'b1000);
      step_to(e + 12);
      raw_down = 1'b0;
      step_to(e + 20); expect_busy(1'b0, "held_after_lock");
      raw_up = 1'b0;
      step_to(e + 30);
      raw_up = 1'b1;
      push(e + 37, 4'b0001);
      step_to(e + 37); expect_busy(1'b1, "repress_start");
      step_to(e + 40);
      raw_up = 1'b0;
      step_to(e + 60);

      // Reset in the middle of lockout with the paddle still held
      e = cyc;
      raw_up = 1'b1;
      push(e + 7, 4'b0001);
      step_to(e + 12);
      rst_n = 1'b0;
      #1;
      expect_all_zero("reset_mid_lockout");
      step_to(e + 15);
      x = cyc;
      rst_n = 1'b1;
      push(x + DEB + 3, 4'b0001);
      step_to(x + 6);  expect_all_zero("after_reset_wait");
      step_to(x + 7);  expect_busy(1'b1, "after_reset_press");
      raw_up = 1'b0;
      step_to(x + 40);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
